// File: rtl/img_pkg.sv
// Shared definitions for the image_processing chain: pooling mode
// encodings, the internal operation enum and small width/saturation helpers.
package img_pkg;

   localparam logic [1:0] MODE_AVG = 2'b00;
   localparam logic [1:0] MODE_MAX = 2'b01;
   localparam logic [1:0] MODE_BYP = 2'b10;

   typedef enum logic [1:0] {
      OP_AVG = 2'b00,
      OP_MAX = 2'b01,
      OP_BYP = 2'b10
   } pool_op_e;

   // Ceiling log2; values 0 and 1 both give 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < $unsigned(value)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Clamp an unsigned value to the largest number representable in out_w bits.
   function automatic logic [31:0] sat(input logic [31:0] value, input int out_w);
      logic [31:0] lim;
      lim = (32'd1 << out_w) - 32'd1;
      return (value > lim) ? lim : value;
   endfunction

   // Mode 2'b11 is an alias for averaging.
   function automatic pool_op_e mode_to_op(input logic [1:0] m);
      pool_op_e op;
      case (m)
         MODE_MAX: op = OP_MAX;
         MODE_BYP: op = OP_BYP;
         default:  op = OP_AVG;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer holding one partial vertical combine per
// horizontal group. Storage and read register carry no reset so the array
// maps onto block or distributed RAM; contents are only read after being
// written within the current window.
module pool_line_buf #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [DEPTH];
   logic [DW-1:0] rd_data_r;

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; data is held until the next read request.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/pooling_stage.sv
// POOL x POOL average / max pooling (or saturating bypass) of a raster
// ordered pixel stream with frame sync, ready/valid on both sides and a
// single output register.
module pooling_stage
   import img_pkg::*;
#(
   parameter int IN_W  = 12,
   parameter int OUT_W = 8,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int POOL  = 2
) (
   input  logic             clk_200mhz,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic [IN_W-1:0]  pixel_in,
   input  logic             sof_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [OUT_W-1:0] pixel_out,
   output logic             eof_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic             sync_err
);

   localparam int LOG2P = clog2(POOL);
   localparam int ACC_W = IN_W + 2 * LOG2P;
   localparam int DEPTH = IMG_W / POOL;
   localparam int CW    = clog2(IMG_W);
   localparam int RW    = clog2(IMG_H);
   localparam int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

   localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
   localparam logic [LOG2P-1:0] PH_LAST  = LOG2P'(POOL - 1);
   localparam logic [LOG2P-1:0] PH_READ  = LOG2P'(POOL - 2);

   logic [CW-1:0]    col_r;
   logic [RW-1:0]    row_r;
   logic [1:0]       mode_q_r;
   logic             sync_err_r;
   logic [ACC_W-1:0] h_acc_r;
   logic             valid_r;
   logic             eof_r;
   logic [OUT_W-1:0] pixel_r;

   logic             accept_s;
   logic [CW-1:0]    col_e_s;
   logic [RW-1:0]    row_e_s;
   pool_op_e         op_s;
   logic             is_max_s;
   logic             grp_first_s;
   logic             grp_last_s;
   logic             rd_phase_s;
   logic             win_first_row_s;
   logic             win_last_row_s;
   logic             eof_s;
   logic [AW-1:0]    addr_s;
   logic [ACC_W-1:0] pix_ext_s;
   logic [ACC_W-1:0] v_s;
   logic [ACC_W-1:0] r_s;
   logic [ACC_W-1:0] buf_rd_s;
   logic             buf_re_s;
   logic             buf_we_s;
   logic [ACC_W-1:0] buf_wd_s;
   logic             load_out_s;
   logic [OUT_W-1:0] out_pix_s;

   function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b,
                                                input logic is_max);
      if (is_max) begin
         return (a > b) ? a : b;
      end else begin
         return a + b;
      end
   endfunction

   assign accept_s  = valid_in && ready_out;
   assign ready_out = !valid_r || ready_in;

   // An sof beat is processed as position (0,0) with the freshly sampled mode.
   assign col_e_s  = sof_in ? {CW{1'b0}} : col_r;
   assign row_e_s  = sof_in ? {RW{1'b0}} : row_r;
   assign op_s     = mode_to_op(sof_in ? mode : mode_q_r);
   assign is_max_s = (op_s == OP_MAX);

   assign grp_first_s     = (col_e_s[LOG2P-1:0] == {LOG2P{1'b0}});
   assign grp_last_s      = (col_e_s[LOG2P-1:0] == PH_LAST);
   assign rd_phase_s      = (col_e_s[LOG2P-1:0] == PH_READ);
   assign win_first_row_s = (row_e_s[LOG2P-1:0] == {LOG2P{1'b0}});
   assign win_last_row_s  = (row_e_s[LOG2P-1:0] == PH_LAST);
   assign eof_s           = (col_e_s == COL_LAST) && (row_e_s == ROW_LAST);
   assign addr_s          = AW'(col_e_s >> LOG2P);

   assign pix_ext_s = {{(2 * LOG2P){1'b0}}, pixel_in};
   assign v_s       = combine(h_acc_r, pix_ext_s, is_max_s);
   assign r_s       = combine(buf_rd_s, v_s, is_max_s);

   // Buffer read is requested one beat ahead of the group's closing beat.
   assign buf_re_s = accept_s && (op_s != OP_BYP) && rd_phase_s;

   pool_line_buf #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (ACC_W)
   ) u_line_buf (
      .clk     (clk_200mhz),
      .wr_en   (buf_we_s),
      .wr_addr (addr_s),
      .wr_data (buf_wd_s),
      .rd_en   (buf_re_s),
      .rd_addr (addr_s),
      .rd_data (buf_rd_s)
   );

   // Decide per accepted beat between buffer update and output generation.
   always_comb begin
      load_out_s = 1'b0;
      buf_we_s   = 1'b0;
      buf_wd_s   = v_s;
      out_pix_s  = {OUT_W{1'b0}};
      if (accept_s) begin
         if (op_s == OP_BYP) begin
            load_out_s = 1'b1;
            out_pix_s  = OUT_W'(sat(32'(pixel_in), OUT_W));
         end else if (grp_last_s && win_last_row_s) begin
            load_out_s = 1'b1;
            out_pix_s  = is_max_s ? OUT_W'(sat(32'(r_s), OUT_W))
                                  : OUT_W'(sat(32'(r_s >> (2 * LOG2P)), OUT_W));
         end else if (grp_last_s) begin
            buf_we_s = 1'b1;
            buf_wd_s = win_first_row_s ? v_s : r_s;
         end else begin
            buf_we_s = 1'b0;
         end
      end else begin
         load_out_s = 1'b0;
      end
   end

   // Raster position, frame mode and sticky sync error.
   always_ff @(posedge clk_200mhz or negedge reset_n) begin
      if (!reset_n) begin
         col_r      <= {CW{1'b0}};
         row_r      <= {RW{1'b0}};
         mode_q_r   <= MODE_AVG;
         sync_err_r <= 1'b0;
      end else if (accept_s) begin
         if (col_e_s == COL_LAST) begin
            col_r <= {CW{1'b0}};
            row_r <= (row_e_s == ROW_LAST) ? {RW{1'b0}} : row_e_s + RW'(1'b1);
         end else begin
            col_r <= col_e_s + CW'(1'b1);
            row_r <= row_e_s;
         end
         if (sof_in) begin
            mode_q_r <= mode;
            if ((col_r != {CW{1'b0}}) || (row_r != {RW{1'b0}})) begin
               sync_err_r <= 1'b1;
            end
         end
      end
   end

   // Horizontal accumulator: loaded on a group's first pixel, combined after.
   always_ff @(posedge clk_200mhz or negedge reset_n) begin
      if (!reset_n) begin
         h_acc_r <= {ACC_W{1'b0}};
      end else if (accept_s) begin
         h_acc_r <= grp_first_s ? pix_ext_s : v_s;
      end
   end

   // Output register: a new result overwrites; otherwise drain on transfer.
   always_ff @(posedge clk_200mhz or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         eof_r   <= 1'b0;
         pixel_r <= {OUT_W{1'b0}};
      end else if (load_out_s) begin
         valid_r <= 1'b1;
         eof_r   <= eof_s;
         pixel_r <= out_pix_s;
      end else if (ready_in) begin
         valid_r <= 1'b0;
         eof_r   <= 1'b0;
      end
   end

   assign valid_out = valid_r;
   assign eof_out   = eof_r;
   assign pixel_out = pixel_r;
   assign sync_err  = sync_err_r;

endmodule

// File: tb/tb_pooling_stage.sv
// Self-checking bench for pooling_stage on a 4x4 frame with 2x2 windows.
module tb_pooling_stage;

   localparam int W = 4;
   localparam int H = 4;
   localparam int P = 2;

   logic        clk;
   logic        reset_n;
   logic [1:0]  mode;
   logic [11:0] pixel_in;
   logic        sof_in;
   logic        valid_in;
   logic        ready_out;
   logic [7:0]  pixel_out;
   logic        eof_out;
   logic        valid_out;
   logic        ready_in;
   logic        sync_err;

   int checks = 0;
   int errors = 0;
   bit bp_on = 1'b0;
   bit chk_ready = 1'b0;
   int frame_pix [W*H];
   int got_pix [$];
   bit got_eof [$];
   int exp_pix [$];
   bit exp_eof [$];

   pooling_stage #(
      .IN_W (12), .OUT_W (8), .IMG_W (W), .IMG_H (H), .POOL (P)
   ) dut (
      .clk_200mhz (clk),
      .reset_n    (reset_n),
      .mode       (mode),
      .pixel_in   (pixel_in),
      .sof_in     (sof_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .pixel_out  (pixel_out),
      .eof_out    (eof_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .sync_err   (sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream readiness: always ready, or ready 70% of cycles under backpressure.
   initial begin
      ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready_in = bp_on ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Output monitor plus ready_out handshake check.
   always @(negedge clk) begin
      if (valid_out === 1'b1 && ready_in === 1'b1) begin
         got_pix.push_back(int'(pixel_out));
         got_eof.push_back(eof_out);
      end
      if (chk_ready) begin
         checks++;
         if (ready_out !== !(valid_out && !ready_in)) begin
            errors++;
            $display("FAIL ready_out: got %b, expected %b (valid_out=%b ready_in=%b)",
                     ready_out, !(valid_out && !ready_in), valid_out, ready_in);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: windows pooled straight from the frame array.
   task automatic build_exp(input logic [1:0] m);
      int sum, mx, val, p;
      exp_pix.delete();
      exp_eof.delete();
      if (m == 2'b10) begin
         for (int i = 0; i < W*H; i++) begin
            exp_pix.push_back(frame_pix[i] > 255 ? 255 : frame_pix[i]);
            exp_eof.push_back(i == W*H-1);
         end
      end else begin
         for (int wr = 0; wr < H/P; wr++) begin
            for (int wc = 0; wc < W/P; wc++) begin
               sum = 0;
               mx = 0;
               for (int dy = 0; dy < P; dy++) begin
                  for (int dx = 0; dx < P; dx++) begin
                     p = frame_pix[(wr*P+dy)*W + wc*P + dx];
                     sum += p;
                     if (p > mx) mx = p;
                  end
               end
               val = (m == 2'b01) ? mx : sum / (P*P);
               exp_pix.push_back(val > 255 ? 255 : val);
               exp_eof.push_back(wr == H/P-1 && wc == W/P-1);
            end
         end
      end
   endtask

   task automatic drive_beat(input int p, input bit s, input logic [1:0] m);
      bit done;
      done = 1'b0;
      valid_in = 1'b1;
      pixel_in = 12'(p);
      sof_in   = s;
      mode     = m;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (ready_out === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drive_beat: input not accepted, got ready_out=%b expected 1 within 100 cycles", ready_out);
      end
   endtask

   // One whole frame; non-sof beats carry a random mode that must be ignored.
   task automatic run_frame(input logic [1:0] m, input int stall_pct);
      for (int idx = 0; idx < W*H; idx++) begin
         if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
         end
         drive_beat(frame_pix[idx], idx == 0, (idx == 0) ? m : 2'($urandom));
      end
      valid_in = 1'b0;
      sof_in   = 1'b0;
   endtask

   task automatic wait_drain(input int n);
      for (int k = 0; k < 300 && got_pix.size() < n; k++) @(negedge clk);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (valid_out !== 1'b0 || pixel_out !== 8'd0 || eof_out !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_in: got v=%b p=%0d e=%b s=%b, expected all 0", valid_out, pixel_out, eof_out, sync_err);
      end
      #21 reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || pixel_out !== 8'd0 || eof_out !== 1'b0 || sync_err !== 1'b0 || ready_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_out: got v=%b p=%0d e=%b s=%b r=%b, expected 0 0 0 0 1",
                  valid_out, pixel_out, eof_out, sync_err, ready_out);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_avg();
      for (int i = 0; i < W*H; i++) frame_pix[i] = i;
      got_pix.delete(); got_eof.delete();
      build_exp(2'b00);
      run_frame(2'b00, 0);
      wait_drain(exp_pix.size());
      checks++;
      if (got_pix.size() != exp_pix.size()) begin
         errors++;
         $display("FAIL avg_count: got %0d outputs, expected %0d", got_pix.size(), exp_pix.size());
      end
      for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
            errors++;
            $display("FAIL avg[%0d]: got %0d eof=%b, expected %0d eof=%b", i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
         end
      end
   endtask

   task automatic test_max_and_sat();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < W*H; i++) frame_pix[i] = i;
         if (pass == 1) frame_pix[0] = 4095;
         got_pix.delete(); got_eof.delete();
         build_exp((pass == 0) ? 2'b01 : 2'b00);
         run_frame((pass == 0) ? 2'b01 : 2'b00, 0);
         wait_drain(exp_pix.size());
         checks++;
         if (got_pix.size() != exp_pix.size()) begin
            errors++;
            $display("FAIL max_sat_count pass %0d: got %0d, expected %0d", pass, got_pix.size(), exp_pix.size());
         end
         for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
               errors++;
               $display("FAIL max_sat pass %0d [%0d]: got %0d eof=%b, expected %0d eof=%b",
                        pass, i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
            end
         end
      end
   endtask

   task automatic test_bypass();
      for (int i = 0; i < W*H; i++) frame_pix[i] = $urandom_range(0, 4095);
      frame_pix[0] = 100; frame_pix[1] = 300; frame_pix[2] = 4095; frame_pix[3] = 0;
      got_pix.delete(); got_eof.delete();
      build_exp(2'b10);
      for (int idx = 0; idx < W*H; idx++) begin
         drive_beat(frame_pix[idx], idx == 0, (idx == 0) ? 2'b10 : 2'($urandom));
         if (idx < 4) begin
            checks++;
            if (valid_out !== 1'b1 || int'(pixel_out) !== exp_pix[idx]) begin
               errors++;
               $display("FAIL bypass_latency[%0d]: got v=%b p=%0d, expected v=1 p=%0d", idx, valid_out, pixel_out, exp_pix[idx]);
            end
         end
      end
      valid_in = 1'b0; sof_in = 1'b0;
      wait_drain(exp_pix.size());
      checks++;
      if (got_pix.size() != exp_pix.size()) begin
         errors++;
         $display("FAIL bypass_count: got %0d, expected %0d", got_pix.size(), exp_pix.size());
      end
      for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
            errors++;
            $display("FAIL bypass[%0d]: got %0d eof=%b, expected %0d eof=%b", i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < W*H; i++) frame_pix[i] = i;
      got_pix.delete(); got_eof.delete();
      build_exp(2'b00);
      bp_on = 1'b1;
      chk_ready = 1'b1;
      run_frame(2'b00, 20);
      wait_drain(exp_pix.size());
      bp_on = 1'b0;
      chk_ready = 1'b0;
      checks++;
      if (got_pix.size() != exp_pix.size()) begin
         errors++;
         $display("FAIL bp_count: got %0d, expected %0d", got_pix.size(), exp_pix.size());
      end
      for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
            errors++;
            $display("FAIL bp[%0d]: got %0d eof=%b, expected %0d eof=%b", i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
         end
      end
   endtask

   task automatic test_sync_err();
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_pre: got %b, expected 0", sync_err);
      end
      got_pix.delete(); got_eof.delete();
      drive_beat($urandom_range(0, 1023), 1'b1, 2'b00);
      drive_beat($urandom_range(0, 1023), 1'b0, 2'b00);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < W*H; i++) frame_pix[i] = $urandom_range(0, 1023);
         got_pix.delete(); got_eof.delete();
         build_exp(2'(f));
         run_frame(2'(f), 10 * f);
         wait_drain(exp_pix.size());
         checks++;
         if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync_sticky frame %0d: got %b, expected 1", f, sync_err);
         end
         checks++;
         if (got_pix.size() != exp_pix.size()) begin
            errors++;
            $display("FAIL sync_count frame %0d: got %0d, expected %0d", f, got_pix.size(), exp_pix.size());
         end
         for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
               errors++;
               $display("FAIL sync frame %0d [%0d]: got %0d eof=%b, expected %0d eof=%b",
                        f, i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 5; i++) drive_beat($urandom_range(1, 4095), i == 0, 2'b10);
      checks++;
      if (valid_out !== 1'b1 || pixel_out === 8'd0) begin
         errors++;
         $display("FAIL pre_reset: got v=%b p=%0d, expected v=1 p!=0", valid_out, pixel_out);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || pixel_out !== 8'd0 || eof_out !== 1'b0 || sync_err !== 1'b0 || ready_out !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got v=%b p=%0d e=%b s=%b r=%b, expected 0 0 0 0 1",
                  valid_out, pixel_out, eof_out, sync_err, ready_out);
      end
      valid_in = 1'b0; sof_in = 1'b0;
      repeat (2) @(posedge clk);
      #4 reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < W*H; i++) frame_pix[i] = i;
      got_pix.delete(); got_eof.delete();
      build_exp(2'b00);
      run_frame(2'b00, 0);
      wait_drain(exp_pix.size());
      checks++;
      if (sync_err !== 1'b0 || got_pix.size() != exp_pix.size()) begin
         errors++;
         $display("FAIL post_reset: got sync_err=%b count=%0d, expected 0 and %0d", sync_err, got_pix.size(), exp_pix.size());
      end
      for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
         checks++;
         if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
            errors++;
            $display("FAIL post_reset[%0d]: got %0d eof=%b, expected %0d eof=%b", i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] m;
      for (int f = 0; f < 6; f++) begin
         m = 2'($urandom_range(0, 3));
         for (int i = 0; i < W*H; i++) frame_pix[i] = $urandom_range(0, (f % 2) ? 4095 : 300);
         got_pix.delete(); got_eof.delete();
         build_exp(m);
         bp_on = 1'b1;
         run_frame(m, 25);
         wait_drain(exp_pix.size());
         bp_on = 1'b0;
         checks++;
         if (got_pix.size() != exp_pix.size()) begin
            errors++;
            $display("FAIL rand_count frame %0d mode %0d: got %0d, expected %0d", f, m, got_pix.size(), exp_pix.size());
         end
         for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i] || got_eof[i] !== exp_eof[i]) begin
               errors++;
               $display("FAIL rand frame %0d mode %0d [%0d]: got %0d eof=%b, expected %0d eof=%b",
                        f, m, i, got_pix[i], got_eof[i], exp_pix[i], exp_eof[i]);
            end
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      mode     = 2'b00;
      pixel_in = 12'd0;
      sof_in   = 1'b0;
      valid_in = 1'b0;
      test_reset();
      test_avg();
      test_max_and_sat();
      test_bypass();
      test_backpressure();
      test_random();
      test_sync_err();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pooling_stage.md
Name: pooling_stage

Overview:
Parametrised successor to the fixed 2x2 average pooling behind the Sobel filter in the image_processing chain.
- Reduces a raster-ordered edge-magnitude stream by POOL x POOL windows.
- Run-time mode: average, max, or saturating bypass.
- Adds frame sync (sof/eof) and a sticky sync-error flag.
- Sits between sobel_filter and parallel2serial in the 200 MHz domain, with ready/valid on both sides.

Parameters:
IN_W, 12, input pixel width (Sobel magnitude)
OUT_W, 8, output pixel width; results saturate to 2^OUT_W-1
IMG_W, 256, input line length in pixels; must be a multiple of POOL
IMG_H, 256, input frame height in lines; must be a multiple of POOL
POOL, 2, window edge; legal values 2 or 4

Ports:
clk_200mhz  in  1  single clock
reset_n  in  1  asynchronous active-low reset
mode  in  2  00=avg, 01=max, 10=bypass, 11=avg; sampled only on an accepted sof_in beat
pixel_in  in  IN_W  input pixel
sof_in  in  1  qualifies pixel_in as the first pixel of a frame
valid_in  in  1  input valid
ready_out  out  1  input ready
pixel_out  out  OUT_W  pooled or bypassed pixel
eof_out  out  1  qualifies pixel_out as the last output of a frame
valid_out  out  1  output valid
ready_in  in  1  downstream ready (backpressure)
sync_err  out  1  sticky; set when sof_in arrives while col/row is not 0

Behaviour:
- Input is accepted when valid_in && ready_out; output transfers when valid_out && ready_in.
- ready_out = !valid_out || ready_in. valid_out, pixel_out and eof_out are held while stalled.
- Reset (asynchronous): valid_out=0, pixel_out=0, eof_out=0, sync_err=0, col=0, row=0, h_acc=0, mode_q=00.
  - Line buffer contents are don't-care.
  - Reset mid-frame drops all partial windows; the next frame must start with sof_in.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, advancing on each accepted beat.
  - col wraps to 0 and increments row; row wraps to 0 after the last line.
- sof_in handling:
  - An accepted sof_in forces the beat to col=0, row=0 and latches mode into mode_q.
  - If col!=0 or row!=0 at that moment, sync_err is set and stays set until reset.
- LOG2P = log2(POOL). ACC_W = IN_W + 2*LOG2P. Line buffer: IMG_W/POOL entries of ACC_W bits.
- avg/max, per accepted beat:
  - h_acc combines pixels in the horizontal group; avg sums, max keeps the largest. The first pixel of a group (col%POOL==0) loads h_acc.
  - At col%POOL==POOL-1, the group value v = combine(h_acc, pixel) updates line buffer entry col/POOL:
    - row%POOL==0: buffer is loaded with v.
    - otherwise: buffer is combined with v.
  - At row%POOL==POOL-1, no buffer write; result r = combine(buf[col/POOL], v) goes to the output register on that same beat.
- Result width: avg gives r >> (2*LOG2P), truncating. Max gives r. Both saturate to OUT_W: any value >= 2^OUT_W becomes all ones.
- bypass: every accepted pixel goes straight to the output register, saturated. The line buffer is unused.
- Latency: valid_out rises the cycle after the window-completing beat (bypass: after each beat).
- One output register; no bubble under continuous flow.
- eof_out = 1 with the output generated by the beat at col=IMG_W-1, row=IMG_H-1, in all modes.
- Output rate: avg/max give one output per POOL*POOL inputs, bypass one per input.
- Simultaneous events:
  - Output transfer and new result in the same cycle: the register is overwritten; no loss.
  - sof_in while sync_err is already set: no further effect.
- mode changes outside an accepted sof_in beat are ignored.

Decomposition:
- Package img_pkg holds:
  - mode encodings MODE_AVG, MODE_MAX, MODE_BYP;
  - functions clog2 and sat(value, OUT_W).
- One sub-module, pool_line_buf: simple dual-port RAM, 1 read and 1 write per cycle.
  - Depth IMG_W/POOL, width ACC_W.
  - Read data is registered; the read address is issued one beat early, at col%POOL==POOL-2 (POOL=2: the group's first beat).
  - Inference-friendly for BRAM/LUTRAM.

Test Plan:
1. Directed avg: IMG_W=4, IMG_H=4, POOL=2, mode=00; frame rows {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}, no stalls -> outputs 2, 4, 10, 12; eof_out only with 12.
2. Directed max, same frame with mode=01 sampled at sof -> outputs 5, 7, 13, 15; saturation check: one pixel = 4095, mode=00 -> that window outputs min(255, sum>>2).
3. Directed bypass: mode=10; pixels 100, 300, 4095, 0 -> outputs 100, 255, 255, 0, each one cycle after acceptance.
4. Directed backpressure: random ready_in at 30%, full avg frame -> output sequence identical to scenario 1; no drop or duplicate; ready_out low exactly when valid_out && !ready_in.
5. Directed sync error: sof_in asserted at col=2 mid-frame -> sync_err=1 stays set; counters restart; the next full frame pools correctly.
6. Directed reset: reset_n pulsed low mid-frame (asynchronous, not clock-aligned) -> all outputs 0 immediately; next sof frame yields scenario-1 results; mode change without sof ignored.
